// File: rtl/map_scroll_fetch.sv
// Map-fetch stage ahead of the colorizer: scrolls DTG coordinates into world space,
// issues the map RAM address and delays coordinates/flags to line up with RAM data.
//
// state  | meaning
// S_IDLE | scroll position held, divider cleared
// S_RUN  | scroll position advances by scroll_step every FRAME_DIV frames
module map_scroll_fetch #(
    parameter int TILE_LOG2     = 3,
    parameter int MAP_COLS_LOG2 = 8,
    parameter int MAP_ROWS      = 96,
    parameter int SCREEN_W      = 1024,
    parameter int ADDR_WIDTH    = 15,
    parameter int MEM_LATENCY   = 1,
    parameter int FRAME_DIV     = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [11:0]           pixel_row,
    input  logic [11:0]           pixel_column,
    input  logic                  video_on,
    input  logic                  frame_start,
    input  logic                  scroll_en,
    input  logic [3:0]            scroll_step,
    input  logic                  scroll_load,
    input  logic [10:0]           scroll_load_val,
    output logic [ADDR_WIDTH-1:0] map_addr,
    output logic [11:0]           world_row,
    output logic [11:0]           world_column,
    output logic                  out_of_map,
    output logic [10:0]           scroll_x,
    output logic                  scrolling
);

    localparam int          ROW_BITS   = ADDR_WIDTH - MAP_COLS_LOG2;
    localparam int          PIPE_DEPTH = 1 + MEM_LATENCY;
    localparam logic [11:0] ROW_LIMIT  = 12'(MAP_ROWS << TILE_LOG2);
    localparam logic [11:0] COL_LIMIT  = 12'(SCREEN_W);
    localparam logic [3:0]  DIV_LAST   = 4'(FRAME_DIV - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                  state_q;
    logic                    scrolling_q;
    logic [3:0]              div_q;
    logic [10:0]             scroll_x_q;
    logic [10:0]             load_val_q;
    logic                    load_pend_q;

    logic [10:0]             wx;
    logic                    oom;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [11:0]             row_q [PIPE_DEPTH];
    logic [11:0]             col_q [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0]   oom_q;

    // World x wraps naturally at the 2048-pixel map width.
    assign wx  = pixel_column[10:0] + scroll_x_q;
    assign oom = !video_on || (pixel_column >= COL_LIMIT) || (pixel_row >= ROW_LIMIT);

    always_comb begin
        addr_d = '0;
        if (!oom) begin
            addr_d = {pixel_row[TILE_LOG2+ROW_BITS-1:TILE_LOG2], wx[10:TILE_LOG2]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q <= '0;
            oom_q  <= '1;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                row_q[i] <= '0;
                col_q[i] <= '0;
            end
        end else begin
            addr_q   <= addr_d;
            row_q[0] <= pixel_row;
            col_q[0] <= {1'b0, wx};
            oom_q    <= {oom_q[PIPE_DEPTH-2:0], oom};
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                row_q[i] <= row_q[i-1];
                col_q[i] <= col_q[i-1];
            end
        end
    end

    // A load arriving on the frame_start cycle is kept pending for the next frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            scrolling_q <= 1'b0;
            div_q       <= '0;
            scroll_x_q  <= '0;
            load_val_q  <= '0;
            load_pend_q <= 1'b0;
        end else begin
            if (frame_start) begin
                case (state_q)
                    S_IDLE: if (scroll_en) begin
                        state_q     <= S_RUN;
                        scrolling_q <= 1'b1;
                    end
                    S_RUN: if (!scroll_en) begin
                        state_q     <= S_IDLE;
                        scrolling_q <= 1'b0;
                    end
                    default: begin
                        state_q     <= S_IDLE;
                        scrolling_q <= 1'b0;
                    end
                endcase

                if (load_pend_q) begin
                    scroll_x_q  <= load_val_q;
                    load_pend_q <= 1'b0;
                    div_q       <= '0;
                end else if (!scroll_en) begin
                    div_q <= '0;
                end else if (div_q >= DIV_LAST) begin
                    div_q      <= '0;
                    scroll_x_q <= scroll_x_q + {7'b0, scroll_step};
                end else begin
                    div_q <= div_q + 4'd1;
                end
            end

            if (scroll_load) begin
                load_val_q  <= scroll_load_val;
                load_pend_q <= 1'b1;
            end
        end
    end

    assign map_addr     = addr_q;
    assign world_row    = row_q[PIPE_DEPTH-1];
    assign world_column = col_q[PIPE_DEPTH-1];
    assign out_of_map   = oom_q[PIPE_DEPTH-1];
    assign scroll_x     = scroll_x_q;
    assign scrolling    = scrolling_q;

endmodule

// File: tb/tb_map_scroll_fetch.sv
// Directed bench for map_scroll_fetch: a default instance (latency 2, FRAME_DIV=1)
// and a second one (MEM_LATENCY=3, FRAME_DIV=4) share the same stimulus.
module tb_map_scroll_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] pixel_row;
    logic [11:0] pixel_column;
    logic        video_on;
    logic        frame_start;
    logic        scroll_en;
    logic [3:0]  scroll_step;
    logic        scroll_load;
    logic [10:0] scroll_load_val;

    logic [14:0] addr1, addr3;
    logic [11:0] wr1, wr3, wc1, wc3;
    logic        oom1, oom3, scr1, scr3;
    logic [10:0] sx1, sx3;

    int tests = 0;
    int fails = 0;

    map_scroll_fetch dut (
        .clk(clk), .reset_n(reset_n), .pixel_row(pixel_row), .pixel_column(pixel_column),
        .video_on(video_on), .frame_start(frame_start), .scroll_en(scroll_en),
        .scroll_step(scroll_step), .scroll_load(scroll_load), .scroll_load_val(scroll_load_val),
        .map_addr(addr1), .world_row(wr1), .world_column(wc1), .out_of_map(oom1),
        .scroll_x(sx1), .scrolling(scr1)
    );

    map_scroll_fetch #(.MEM_LATENCY(3), .FRAME_DIV(4)) dut3 (
        .clk(clk), .reset_n(reset_n), .pixel_row(pixel_row), .pixel_column(pixel_column),
        .video_on(video_on), .frame_start(frame_start), .scroll_en(scroll_en),
        .scroll_step(scroll_step), .scroll_load(scroll_load), .scroll_load_val(scroll_load_val),
        .map_addr(addr3), .world_row(wr3), .world_column(wc3), .out_of_map(oom3),
        .scroll_x(sx3), .scrolling(scr3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input logic [11:0] r, input logic [11:0] c, input logic v);
        pixel_row    = r;
        pixel_column = c;
        video_on     = v;
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; frame_start = 1'b0; scroll_en = 1'b0; scroll_step = 4'd0;
        scroll_load = 1'b0; scroll_load_val = 11'd0;
        set_px(12'd10, 12'd20, 1'b1);
        repeat (3) tick();
        tests++; if (addr1 !== 15'd0) begin fails++; $display("FAIL reset_addr: got %0d want 0", addr1); end
        tests++; if (wr1 !== 12'd0 || wc1 !== 12'd0) begin fails++; $display("FAIL reset_world: got row %0d col %0d want 0 0", wr1, wc1); end
        tests++; if (oom1 !== 1'b1 || oom3 !== 1'b1) begin fails++; $display("FAIL reset_oom: got %b/%b want 1/1", oom1, oom3); end
        tests++; if (sx1 !== 11'd0 || scr1 !== 1'b0) begin fails++; $display("FAIL reset_scroll: got x %0d run %b want 0 0", sx1, scr1); end
        reset_n = 1'b1;
        tick();
        tests++; if (oom1 !== 1'b1) begin fails++; $display("FAIL post_reset_oom_c1: got %b want 1", oom1); end
        tick();
        tests++; if (oom1 !== 1'b0 || oom3 !== 1'b1) begin fails++; $display("FAIL post_reset_oom_c2: got %b/%b want 0/1", oom1, oom3); end
        tick();
        tests++; if (oom3 !== 1'b1) begin fails++; $display("FAIL post_reset_oom3_c3: got %b want 1", oom3); end
        tick();
        tests++; if (oom3 !== 1'b0) begin fails++; $display("FAIL post_reset_oom3_c4: got %b want 0", oom3); end
    endtask

    task automatic test_addressing();
        set_px(12'd0, 12'd0, 1'b0);
        repeat (4) tick();
        set_px(12'd10, 12'd20, 1'b1);
        tick();
        tests++; if (addr1 !== 15'd258) begin fails++; $display("FAIL addr_10_20: got %0d want 258", addr1); end
        set_px(12'd100, 12'd500, 1'b1);
        tick();
        tests++; if (wr1 !== 12'd10 || wc1 !== 12'd20 || oom1 !== 1'b0) begin
            fails++; $display("FAIL aligned_10_20: got row %0d col %0d oom %b want 10 20 0", wr1, wc1, oom1); end
        tests++; if (addr1 !== 15'd3134) begin fails++; $display("FAIL addr_100_500: got %0d want 3134", addr1); end
        set_px(12'd0, 12'd0, 1'b0);
        tick();
        tests++; if (wr1 !== 12'd100 || wc1 !== 12'd500) begin
            fails++; $display("FAIL aligned_100_500: got row %0d col %0d want 100 500", wr1, wc1); end
        tests++; if (oom3 !== 1'b1) begin fails++; $display("FAIL lat4_early: got %b want 1", oom3); end
        tick();
        tests++; if (wr3 !== 12'd10 || wc3 !== 12'd20 || oom3 !== 1'b0) begin
            fails++; $display("FAIL lat4_10_20: got row %0d col %0d oom %b want 10 20 0", wr3, wc3, oom3); end
    endtask

    task automatic test_autoscroll();
        scroll_en = 1'b1;
        scroll_step = 4'd3;
        for (int i = 1; i <= 3; i++) begin
            frame_pulse();
            tests++; if (sx1 !== 11'(3 * i) || scr1 !== 1'b1) begin
                fails++; $display("FAIL autoscroll_%0d: got x %0d run %b want %0d 1", i, sx1, scr1, 3 * i); end
        end
        tests++; if (sx3 !== 11'd0 || scr3 !== 1'b1) begin
            fails++; $display("FAIL div4_hold: got x %0d run %b want 0 1", sx3, scr3); end
        set_px(12'd10, 12'd1020, 1'b1);
        tick();
        tests++; if (addr1 !== 15'd384) begin fails++; $display("FAIL addr_scrolled: got %0d want 384", addr1); end
        set_px(12'd0, 12'd0, 1'b0);
        tick();
        tests++; if (wc1 !== 12'd1029 || oom1 !== 1'b0) begin
            fails++; $display("FAIL world_scrolled: got col %0d oom %b want 1029 0", wc1, oom1); end
    endtask

    task automatic test_wrap();
        scroll_load_val = 11'd2040;
        scroll_load = 1'b1;
        tick();
        scroll_load = 1'b0;
        tests++; if (sx1 !== 11'd9) begin fails++; $display("FAIL load_midframe: got %0d want 9", sx1); end
        frame_pulse();
        tests++; if (sx1 !== 11'd2040 || sx3 !== 11'd2040) begin
            fails++; $display("FAIL load_apply: got %0d/%0d want 2040/2040", sx1, sx3); end
        set_px(12'd10, 12'd10, 1'b1);
        tick();
        tests++; if (addr1 !== 15'd256) begin fails++; $display("FAIL addr_wrap: got %0d want 256", addr1); end
        set_px(12'd0, 12'd0, 1'b0);
        tick();
        tests++; if (wc1 !== 12'd2) begin fails++; $display("FAIL world_wrap: got %0d want 2", wc1); end
        scroll_step = 4'd12;
        frame_pulse();
        tests++; if (sx1 !== 11'd4 || sx3 !== 11'd2040) begin
            fails++; $display("FAIL step_wrap: got %0d/%0d want 4/2040", sx1, sx3); end
    endtask

    task automatic test_out_of_map();
        logic [11:0] rows [3];
        logic [11:0] cols [3];
        logic        vons [3];
        rows[0] = 12'd768; cols[0] = 12'd20;   vons[0] = 1'b1;
        rows[1] = 12'd10;  cols[1] = 12'd1024; vons[1] = 1'b1;
        rows[2] = 12'd10;  cols[2] = 12'd20;   vons[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_px(12'd10, 12'd20, 1'b1);
            repeat (4) tick();
            set_px(rows[k], cols[k], vons[k]);
            tick();
            tests++; if (addr1 !== 15'd0) begin fails++; $display("FAIL oom_addr_%0d: got %0d want 0", k, addr1); end
            set_px(12'd10, 12'd20, 1'b1);
            tick();
            tests++; if (oom1 !== 1'b1 || wr1 !== rows[k]) begin
                fails++; $display("FAIL oom_lat2_%0d: got oom %b row %0d want 1 %0d", k, oom1, wr1, rows[k]); end
            tick();
            tests++; if (oom1 !== 1'b0 || oom3 !== 1'b0) begin
                fails++; $display("FAIL oom_lat3_%0d: got %b/%b want 0/0", k, oom1, oom3); end
            tick();
            tests++; if (oom3 !== 1'b1) begin fails++; $display("FAIL oom_lat4_%0d: got %b want 1", k, oom3); end
        end
        set_px(12'd767, 12'd1023, 1'b1);
        tick();
        tests++; if (addr1 !== 15'd24448) begin fails++; $display("FAIL addr_edge: got %0d want 24448", addr1); end
        set_px(12'd10, 12'd20, 1'b1);
        tick();
        tests++; if (oom1 !== 1'b0 || wr1 !== 12'd767 || wc1 !== 12'd1027) begin
            fails++; $display("FAIL world_edge: got oom %b row %0d col %0d want 0 767 1027", oom1, wr1, wc1); end
    endtask

    task automatic test_midframe_control();
        scroll_load_val = 11'd500;
        scroll_load = 1'b1;
        tick();
        scroll_load = 1'b0;
        scroll_en = 1'b0;
        tick();
        tick();
        scroll_load_val = 11'd700;
        scroll_load = 1'b1;
        tick();
        scroll_load = 1'b0;
        scroll_en = 1'b1;
        tick();
        scroll_en = 1'b0;
        tick();
        tests++; if (sx1 !== 11'd4 || sx3 !== 11'd2040 || scr1 !== 1'b1) begin
            fails++; $display("FAIL midframe_hold: got %0d/%0d run %b want 4/2040 1", sx1, sx3, scr1); end
        frame_pulse();
        tests++; if (sx1 !== 11'd700 || sx3 !== 11'd700) begin
            fails++; $display("FAIL last_load_wins: got %0d/%0d want 700/700", sx1, sx3); end
        tests++; if (scr1 !== 1'b0 || scr3 !== 1'b0) begin
            fails++; $display("FAIL fsm_idle: got %b/%b want 0/0", scr1, scr3); end
        scroll_en = 1'b1;
        scroll_step = 4'd5;
        for (int i = 1; i <= 4; i++) begin
            frame_pulse();
            tests++; if (sx3 !== ((i < 4) ? 11'd700 : 11'd705) || scr3 !== 1'b1) begin
                fails++; $display("FAIL div4_frame_%0d: got x %0d run %b want %0d 1", i, sx3, scr3, (i < 4) ? 700 : 705); end
        end
        tests++; if (sx1 !== 11'd720) begin fails++; $display("FAIL div1_frames: got %0d want 720", sx1); end
        scroll_load_val = 11'd100;
        scroll_load = 1'b1;
        frame_start = 1'b1;
        tick();
        scroll_load = 1'b0;
        frame_start = 1'b0;
        tests++; if (sx1 !== 11'd725 || sx3 !== 11'd705) begin
            fails++; $display("FAIL load_on_frame: got %0d/%0d want 725/705", sx1, sx3); end
        frame_pulse();
        tests++; if (sx1 !== 11'd100 || sx3 !== 11'd100) begin
            fails++; $display("FAIL load_next_frame: got %0d/%0d want 100/100", sx1, sx3); end
        scroll_step = 4'd0;
        frame_pulse();
        frame_pulse();
        tests++; if (sx1 !== 11'd100 || scr1 !== 1'b1) begin
            fails++; $display("FAIL step_zero: got x %0d run %b want 100 1", sx1, scr1); end
    endtask

    initial begin
        test_reset();
        test_addressing();
        test_autoscroll();
        test_wrap();
        test_out_of_map();
        test_midframe_control();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
